// File: rtl/ysyx_23060201_mem_arbiter.sv
// Single-port memory arbiter shared by the instruction fetch unit (IFU) and
// the load/store unit (LSU). One transaction is in flight at a time.
// LSU has fixed priority. A streak counter bounds how many LSU grants can
// pass a waiting IFU request.
module ysyx_23060201_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // IFU request / response
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_resp_data,
  // LSU request / response
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_req_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
  input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
  input  logic [7:0]            lsu_req_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
  // Shared memory port
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [7:0]            mem_req_wmask,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  // Status
  output logic                  busy
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE   = STREAK_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_e;

  state_e                state_q;
  owner_e                owner_q;
  logic [STREAK_W-1:0]   streak_q, streak_d;

  logic                  req_wen_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [7:0]            req_wmask_q;
  logic [DATA_WIDTH-1:0] resp_data_q;

  logic                  mem_req_valid_q;
  logic                  mem_resp_ready_q;
  logic                  ifu_resp_valid_q;
  logic                  lsu_resp_valid_q;
  logic                  busy_q;

  logic                  in_idle;
  logic                  lsu_held_off;
  logic                  grant_lsu;
  logic                  grant_ifu;
  logic                  owner_resp_ready;

  // Grant decision: LSU wins unless the IFU has waited out a full streak.
  assign in_idle      = (state_q == IDLE);
  assign lsu_held_off = ifu_req_valid && (streak_q == STREAK_LIMIT);
  assign grant_lsu    = in_idle && lsu_req_valid && !lsu_held_off;
  assign grant_ifu    = in_idle && ifu_req_valid && !grant_lsu;

  assign lsu_req_ready = grant_lsu;
  assign ifu_req_ready = grant_ifu;

  assign owner_resp_ready = (owner_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;

  // Streak bookkeeping: counts LSU grants taken while the IFU was waiting.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
    streak_d = streak_q;
    if (grant_lsu) begin
      if (!ifu_req_valid) begin
        streak_d = '0;
      end else if (streak_q != STREAK_LIMIT) begin
        streak_d = streak_q + STREAK_ONE;
      end
    end else if (grant_ifu) begin
      streak_d = '0;
    end
  end

  // Transaction FSM with registered request fields, response data and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      owner_q          <= OWNER_IFU;
      streak_q         <= '0;
      req_wen_q        <= 1'b0;
      req_addr_q       <= '0;
      req_wdata_q      <= '0;
      req_wmask_q      <= '0;
      resp_data_q      <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_resp_ready_q <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      streak_q <= streak_d;
      case (state_q)
        IDLE: begin
          if (grant_lsu) begin
            owner_q         <= OWNER_LSU;
            req_wen_q       <= lsu_req_wen;
            req_addr_q      <= lsu_req_addr;
            req_wdata_q     <= lsu_req_wdata;
            req_wmask_q     <= lsu_req_wmask;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= REQ;
          end else if (grant_ifu) begin
            owner_q         <= OWNER_IFU;
            req_wen_q       <= 1'b0;
            req_addr_q      <= ifu_req_addr;
            req_wdata_q     <= '0;
            req_wmask_q     <= '0;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
            state_q          <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            // Stores still get a memory response, but report zero data upstream.
            resp_data_q      <= req_wen_q ? '0 : mem_resp_rdata;
            mem_resp_ready_q <= 1'b0;
            ifu_resp_valid_q <= (owner_q == OWNER_IFU);
            lsu_resp_valid_q <= (owner_q == OWNER_LSU);
            state_q          <= RESP;
          end
        end
        RESP: begin
          if (owner_resp_ready) begin
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            busy_q           <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_wen    = req_wen_q;
  assign mem_req_addr   = req_addr_q;
  assign mem_req_wdata  = req_wdata_q;
  assign mem_req_wmask  = req_wmask_q;
  assign mem_resp_ready = mem_resp_ready_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign ifu_resp_data  = resp_data_q;
  assign lsu_resp_rdata = resp_data_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Self-checking bench for ysyx_23060201_mem_arbiter. The bench plays IFU,
// LSU and memory. A transaction-level model tracks the obligations that are
// open (request to memory, memory response, response to owner) and predicts
// every handshake output each cycle.
module tb_ysyx_23060201_mem_arbiter;

  localparam int MAX_STREAK = 4;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        busy;

  ysyx_23060201_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_resp_data  (ifu_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_resp_rdata (lsu_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_rdata (mem_resp_rdata),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters
  int n_checks = 0;
  int n_errors = 0;

  // Model: open obligations of the single in-flight transaction
  bit          m_busy, m_owner_lsu, m_need_req, m_need_resp, m_have_resp;
  logic        m_wen;
  logic [31:0] m_addr, m_wdata, m_data;
  logic [7:0]  m_wmask;
  int          m_streak;
  int          wc;

  // Stimulus knobs (percentages)
  int          ifu_gen_pct, lsu_gen_pct, mem_ready_pct, mem_resp_pct;
  int          mem_resp_delay, stray_pct, resp_ready_pct;
  bit          force_rdata;
  logic [31:0] forced_rdata;

  // Observations
  logic        last_mreq_wen;
  logic [31:0] last_mreq_addr, last_mreq_wdata, last_ifu_data, last_lsu_data;
  logic [7:0]  last_mreq_wmask;
  int          lsu_resp_seen, busy_seen, mreq_seen, mresp_rdy_seen;
  int          cyc, n_grants, last_acc_cyc, bad_spacing;
  logic [31:0] grant_bits;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit rnd(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic reset_model();
    m_busy = 0; m_owner_lsu = 0; m_need_req = 0; m_need_resp = 0; m_have_resp = 0;
    m_wen = 0; m_addr = '0; m_wdata = '0; m_data = '0; m_wmask = '0;
    m_streak = 0; wc = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_mem_resp_ready"}, mem_resp_ready, 0);
    check({tag, "_ifu_resp_valid"}, ifu_resp_valid, 0);
    check({tag, "_lsu_resp_valid"}, lsu_resp_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_req_fields"}, {mem_req_wen, mem_req_addr, mem_req_wmask, mem_req_wdata[22:0]}, 0);
    check({tag, "_resp_data"}, {ifu_resp_data, lsu_resp_rdata}, 0);
  endtask

  // Requesters and memory react to the handshakes of the edge just taken.
  task automatic drive_agents(input bit acc_i, input bit acc_l);
    if (acc_i) ifu_req_valid = 1'b0;
    if (acc_l) lsu_req_valid = 1'b0;
    if (!ifu_req_valid && rnd(ifu_gen_pct)) begin
      ifu_req_valid = 1'b1;
      ifu_req_addr  = $urandom & 32'hFFFF_FFFC;
    end
    if (!lsu_req_valid && rnd(lsu_gen_pct)) begin
      lsu_req_valid = 1'b1;
      lsu_req_wen   = 1'($urandom_range(1));
      lsu_req_addr  = $urandom & 32'hFFFF_FFFC;
      lsu_req_wdata = $urandom;
      lsu_req_wmask = 8'($urandom_range(255));
    end
    mem_req_ready = rnd(mem_ready_pct);
    if (m_need_resp) mem_resp_valid = (wc >= mem_resp_delay) && rnd(mem_resp_pct);
    else             mem_resp_valid = rnd(stray_pct);
    mem_resp_rdata = force_rdata ? forced_rdata : $urandom;
    ifu_resp_ready = rnd(resp_ready_pct);
    lsu_resp_ready = rnd(resp_ready_pct);
  endtask

  // One clock cycle: inputs are already driven at the falling edge.
  task automatic cycle();
    bit exp_l, exp_i;
    #1;
    exp_l = !m_busy && lsu_req_valid && !(ifu_req_valid && m_streak == MAX_STREAK);
    exp_i = !m_busy && ifu_req_valid && !exp_l;
    check("lsu_req_ready", lsu_req_ready, exp_l);
    check("ifu_req_ready", ifu_req_ready, exp_i);
    check("busy", busy, m_busy);
    check("mem_req_valid", mem_req_valid, m_need_req);
    if (m_need_req) begin
      check("mem_req_addr", mem_req_addr, m_addr);
      check("mem_req_wen", mem_req_wen, m_wen);
      check("mem_req_wdata", mem_req_wdata, m_wdata);
      check("mem_req_wmask", mem_req_wmask, m_wmask);
    end
    check("mem_resp_ready", mem_resp_ready, m_need_resp);
    check("ifu_resp_valid", ifu_resp_valid, m_have_resp && !m_owner_lsu);
    check("lsu_resp_valid", lsu_resp_valid, m_have_resp && m_owner_lsu);
    if (m_have_resp) begin
      if (m_owner_lsu) check("lsu_resp_rdata", lsu_resp_rdata, m_data);
      else             check("ifu_resp_data", ifu_resp_data, m_data);
    end
    if (busy) busy_seen++;
    if (mem_req_valid) mreq_seen++;
    if (mem_resp_ready) mresp_rdy_seen++;
    if (lsu_resp_valid) lsu_resp_seen++;

    if (exp_l || exp_i) begin
      m_busy = 1; m_need_req = 1; m_owner_lsu = exp_l;
      grant_bits = {grant_bits[30:0], exp_l};
      n_grants++;
      if (n_grants > 1 && cyc - last_acc_cyc != 4) bad_spacing++;
      last_acc_cyc = cyc;
      if (exp_l) begin
        m_wen = lsu_req_wen; m_addr = lsu_req_addr; m_wdata = lsu_req_wdata; m_wmask = lsu_req_wmask;
        if (!ifu_req_valid) m_streak = 0;
        else if (m_streak < MAX_STREAK) m_streak++;
      end else begin
        m_wen = 0; m_addr = ifu_req_addr; m_wdata = '0; m_wmask = '0;
        m_streak = 0;
      end
    end else if (m_need_req && mem_req_ready) begin
      m_need_req = 0; m_need_resp = 1; wc = 0;
      last_mreq_wen = mem_req_wen; last_mreq_addr = mem_req_addr;
      last_mreq_wdata = mem_req_wdata; last_mreq_wmask = mem_req_wmask;
    end else if (m_need_resp && mem_resp_valid) begin
      m_need_resp = 0; m_have_resp = 1;
      m_data = m_wen ? 32'h0 : mem_resp_rdata;
    end else if (m_have_resp && (m_owner_lsu ? lsu_resp_ready : ifu_resp_ready)) begin
      m_have_resp = 0; m_busy = 0;
      if (m_owner_lsu) last_lsu_data = lsu_resp_rdata;
      else             last_ifu_data = ifu_resp_data;
    end else if (m_need_resp) begin
      wc++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    drive_agents(exp_i, exp_l);
  endtask

  // Run until the transaction in flight (or the next one accepted) completes.
  task automatic run_txn(input string tag);
    bit started = m_busy;
    bit done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      cycle();
      if (m_busy) started = 1;
      else if (started) done = 1;
    end
    if (!done) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic set_knobs(input int gen, input int mrdy, input int mresp, input int dly,
                           input int stray, input int rrdy);
    ifu_gen_pct = gen; lsu_gen_pct = gen; mem_ready_pct = mrdy; mem_resp_pct = mresp;
    mem_resp_delay = dly; stray_pct = stray; resp_ready_pct = rrdy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 0;
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_wen = 0; lsu_req_addr = '0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    force_rdata = 0; forced_rdata = '0;
    cyc = 0; n_grants = 0; last_acc_cyc = 0; bad_spacing = 0; grant_bits = '0;
    lsu_resp_seen = 0; busy_seen = 0; mreq_seen = 0; mresp_rdy_seen = 0;
    reset_model();
    set_knobs(0, 100, 100, 0, 0, 100);
    #1;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1;
    ifu_resp_ready = 1; lsu_resp_ready = 1; mem_req_ready = 1;

    // Single IFU read, memory answers after one wait cycle
    set_knobs(0, 100, 100, 1, 0, 100);
    force_rdata = 1; forced_rdata = 32'h0000_0413;
    lsu_resp_seen = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    run_txn("t1");
    check("t1_mem_addr", last_mreq_addr, 32'h8000_0000);
    check("t1_mem_wen", last_mreq_wen, 0);
    check("t1_ifu_data", last_ifu_data, 32'h0000_0413);
    check("t1_lsu_resp_seen", lsu_resp_seen, 0);

    // LSU store at zero wait
    set_knobs(0, 100, 100, 0, 0, 100);
    forced_rdata = 32'h1234_5678;
    mem_resp_rdata = forced_rdata;
    lsu_req_valid = 1; lsu_req_wen = 1; lsu_req_addr = 32'h8000_0100;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wmask = 8'h0F;
    busy_seen = 0;
    run_txn("t2");
    check("t2_mem_wen", last_mreq_wen, 1);
    check("t2_mem_addr", last_mreq_addr, 32'h8000_0100);
    check("t2_mem_wdata", last_mreq_wdata, 32'hDEAD_BEEF);
    check("t2_mem_wmask", last_mreq_wmask, 8'h0F);
    check("t2_lsu_rdata", last_lsu_data, 32'h0);
    check("t2_occupancy", busy_seen + 1, 4);
    force_rdata = 0;

    // Both requesters continuously valid
    set_knobs(100, 100, 100, 0, 0, 100);
    n_grants = 0; bad_spacing = 0; grant_bits = '0;
    for (int n = 0; n < 200 && n_grants < 10; n++) cycle();
    check("t3_grant_count", n_grants, 10);
    check("t3_grant_order", grant_bits[9:0], 10'b1111011110);
    check("t3_accept_spacing_bad", bad_spacing, 0);
    set_knobs(0, 100, 100, 0, 0, 100);
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      cycle();
      ok = !m_busy && !ifu_req_valid && !lsu_req_valid;
    end
    check("t3_drain", ok, 1);

    // Backpressure on both the memory request and the LSU response
    set_knobs(0, 0, 100, 0, 0, 100);
    mem_req_ready = 0;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_0200;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 8'hFF;
    cycle();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    mreq_seen = 0;
    repeat (5) cycle();
    check("t4_req_hold", mreq_seen, 5);
    mem_ready_pct = 100; mem_req_ready = 1;
    resp_ready_pct = 0; lsu_resp_ready = 0; ifu_resp_ready = 0;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      cycle();
      ok = m_have_resp;
    end
    check("t4_resp_reached", ok, 1);
    lsu_resp_seen = 0;
    repeat (3) cycle();
    check("t4_resp_hold", lsu_resp_seen, 3);
    resp_ready_pct = 100; lsu_resp_ready = 1; ifu_resp_ready = 1;
    run_txn("t4_lsu");
    run_txn("t4_ifu");
    check("t4_ifu_addr", last_mreq_addr, 32'h8000_0004);

    // Stray memory responses in IDLE and REQ
    set_knobs(0, 0, 100, 0, 100, 100);
    mem_resp_valid = 1; mem_req_ready = 0;
    mresp_rdy_seen = 0; busy_seen = 0;
    repeat (3) cycle();
    check("t5_idle_resp_ready", mresp_rdy_seen, 0);
    check("t5_idle_busy", busy_seen, 0);
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010;
    cycle();
    mresp_rdy_seen = 0; mreq_seen = 0;
    repeat (3) cycle();
    check("t5_req_resp_ready", mresp_rdy_seen, 0);
    check("t5_req_hold", mreq_seen, 3);
    mem_ready_pct = 100; mem_req_ready = 1;
    run_txn("t5");
    check("t5_ifu_addr", last_mreq_addr, 32'h8000_0010);

    // Reset pulsed while waiting for memory
    set_knobs(0, 100, 0, 0, 0, 100);
    mem_resp_valid = 0;
    lsu_req_valid = 1; lsu_req_wen = 0; lsu_req_addr = 32'h8000_0300;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      cycle();
      ok = m_need_resp;
    end
    check("t6_wait_reached", ok, 1);
    cycle();
    rst_n = 0;
    #1;
    check_reset_outputs("t6_rst");
    reset_model();
    ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    mem_resp_pct = 100;
    force_rdata = 1; forced_rdata = 32'h0000_0093;
    mem_resp_rdata = forced_rdata;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    run_txn("t6");
    check("t6_ifu_data", last_ifu_data, 32'h0000_0093);
    force_rdata = 0;

    // Randomised traffic
    for (int seg = 0; seg < 8; seg++) begin
      ifu_gen_pct    = int'($urandom_range(100, 20));
      lsu_gen_pct    = int'($urandom_range(100, 20));
      mem_ready_pct  = int'($urandom_range(100, 30));
      mem_resp_pct   = int'($urandom_range(100, 30));
      mem_resp_delay = int'($urandom_range(3));
      stray_pct      = int'($urandom_range(30));
      resp_ready_pct = int'($urandom_range(100, 30));
      repeat (250) cycle();
    end
    set_knobs(0, 100, 100, 0, 0, 100);
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      cycle();
      ok = !m_busy && !ifu_req_valid && !lsu_req_valid;
    end
    check("rand_drain", ok, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
